// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) inverse-cipher primitives
// for the iterative AES-128 decryption sequencer.
package aes_pkg;

    localparam int NR      = 10;
    localparam int RW      = 4;
    localparam int RK_INIT = NR;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
        logic [7:0] y;
        y = 8'h00;
        for (int i = 0; i < 8; i++)
            y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
        return gf_inv(y ^ 8'h05);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round body: InvShiftRows wiring, InvSubBytes, AddRoundKey
// and InvMixColumns (skipped on the final round). back_only treats st as already substituted.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         final_rnd,
    input  logic         back_only,
    output logic [127:0] nxt
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;

    // Byte (r,c) lives at bits [127-8*(4c+r) -: 8]; row r rotates right by r columns.
    always_comb begin
        shifted = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                shifted[8*(15 - 4*c - r) +: 8] = st[8*(15 - 4*((c - r + 4) % 4) - r) +: 8];
    end

    always_comb begin
        subbed = '0;
        for (int k = 0; k < 16; k++)
            subbed[8*k +: 8] = inv_sub_byte(shifted[8*k +: 8]);
    end

    assign keyed = (back_only ? st : subbed) ^ rk;

    always_comb begin
        mixed = '0;
        for (int j = 0; j < 4; j++)
            mixed[32*j +: 32] = inv_mix_col(keyed[32*j +: 32]);
    end

    assign nxt = final_rnd ? keyed : mixed;

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 decryption sequencer: one inverse round per clock, or two clocks
// per round when AES_DEC_SPLIT_ROUND_EN is defined.
module aes_dec_round_ctrl #(
    parameter int NR = aes_pkg::NR,
    parameter int RW = aes_pkg::RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  ct,
    output logic [RW-1:0] rk_idx,
    input  logic [127:0]  rk,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  pt,
    output logic          busy
);
    import aes_pkg::*;

    state_t         state;
    state_t         state_nxt;
    logic [127:0]   st_reg;
    logic [RW-1:0]  round;
    logic [127:0]   rnd_st;
    logic [127:0]   rnd_rk;
    logic [127:0]   rnd_nxt;
    logic           rnd_final;
    logic           rnd_back;
    logic           round_end;

`ifdef AES_DEC_SPLIT_ROUND_EN
    logic           phase;
    logic [127:0]   mid_reg;

    // Phase A reuses the round body with a zero key and no InvMix to get InvSub(InvShift(st)).
    assign rnd_st    = phase ? mid_reg : st_reg;
    assign rnd_rk    = phase ? rk : '0;
    assign rnd_final = phase ? (round == '0) : 1'b1;
    assign rnd_back  = phase;
    assign round_end = phase && (round == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              phase <= 1'b0;
        else if (state == RUN)   phase <= ~phase;
        else                     phase <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (state == RUN && !phase) mid_reg <= rnd_nxt;
    end
`else
    assign rnd_st    = st_reg;
    assign rnd_rk    = rk;
    assign rnd_final = (round == '0);
    assign rnd_back  = 1'b0;
    assign round_end = (round == '0);
`endif

    aes_inv_round u_round (
        .st        (rnd_st),
        .rk        (rnd_rk),
        .final_rnd (rnd_final),
        .back_only (rnd_back),
        .nxt       (rnd_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (round_end) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_reg <= '0;
            round  <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                st_reg <= ct ^ rk;
                round  <= RW'(NR - 1);
            end
        end else if (state == RUN) begin
`ifdef AES_DEC_SPLIT_ROUND_EN
            if (phase) begin
                st_reg <= rnd_nxt;
                if (round != '0) round <= round - 1'b1;
            end
`else
            st_reg <= rnd_nxt;
            if (round != '0) round <= round - 1'b1;
`endif
        end
    end

    // In IDLE the index points at the key for the initial AddRoundKey.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign rk_idx    = (state == IDLE) ? RW'(RK_INIT) : round;
    assign pt        = (state == DONE) ? st_reg : '0;

endmodule
